// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell plus a registered borrow,
// LSB first, with valid/ready handshakes on the operand and result sides.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_sh_r;
  logic             br_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic [CW-1:0]    cnt_r;
  logic             d_s;
  logic             bn_s;
  logic             accept_s;
  logic             last_s;
  logic [WIDTH-1:0] result_s;

  // Full-subtractor cell: returns {borrow_next, difference_bit}.
  function automatic logic [1:0] fs_cell(input logic x, input logic y, input logic bin);
    fs_cell = {(~x & y) | (~(x ^ y) & bin), x ^ y ^ bin};
  endfunction

  // Current-bit arithmetic and handshake/terminal-count decode.
  always_comb begin
    {bn_s, d_s} = fs_cell(a_sh_r[0], b_sh_r[0], br_r);
    result_s    = {d_s, res_sh_r[WIDTH-1:1]};
    accept_s    = in_valid & in_ready;
    last_s      = (cnt_r == CW'(WIDTH - 1));
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = RUN;
        else          next_state_s = IDLE;
      end
      RUN: begin
        if (last_s) next_state_s = DONE;
        else        next_state_s = RUN;
      end
      DONE: begin
        if (out_ready) next_state_s = IDLE;
        else           next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_state_s;
  end

  // Handshake flags; in_ready is registered so it stays low throughout reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready <= (next_state_s == IDLE);
      if (state_r == RUN && last_s)            out_valid <= 1'b1;
      else if (state_r == DONE && out_ready)   out_valid <= 1'b0;
      else                                     out_valid <= out_valid;
    end
  end

  // Shift datapath; result registers move only on the final RUN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r     <= '0;
      b_sh_r     <= '0;
      res_sh_r   <= '0;
      br_r       <= 1'b0;
      cnt_r      <= '0;
      a_msb_r    <= 1'b0;
      b_msb_r    <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            br_r    <= 1'b0;
            cnt_r   <= '0;
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b[WIDTH-1];
          end
        end
        RUN: begin
          res_sh_r <= result_s;
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          br_r     <= bn_s;
          cnt_r    <= cnt_r + CW'(1);
          if (last_s) begin
            diff       <= result_s;
            borrow_out <= bn_s;
            ovf        <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
          end
        end
        DONE: begin
          br_r <= br_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 instance plus
// a WIDTH=4 instance swept exhaustively).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, borrow_out, ovf;
  logic [7:0] a, b, diff;
  logic       in_valid4, in_ready4, out_valid4, out_ready4, borrow_out4, ovf4;
  logic [3:0] a4, b4, diff4;

  int checks = 0;
  int errors = 0;
  int pulses4 = 0;
  int accepts4 = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow_out(borrow_out), .ovf(ovf)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .diff(diff4), .borrow_out(borrow_out4), .ovf(ovf4)
  );

  // Handshake counters for the 4-bit instance.
  always @(posedge clk) begin
    if (!rst && out_valid4 && out_ready4) pulses4 <= pulses4 + 1;
    if (!rst && in_valid4 && in_ready4)   accepts4 <= accepts4 + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_op(input logic [7:0] av, input logic [7:0] bv, output bit ok);
    a = av;
    b = bv;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      else step();
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    ok = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (diff !== 8'h00) begin errors++; $display("FAIL rst_diff got %h want 00", diff); end
    checks++; if ({borrow_out, ovf} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b want 00", {borrow_out, ovf}); end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    bit ok, ok2;
    int cyc;
    out_ready = 1'b1;
    accept_op(8'd100, 8'd37, ok);
    wait_done(ok2, cyc);
    checks++; if (!ok || !ok2 || cyc != 8) begin errors++; $display("FAIL basic_latency got %0d want 8 (accept %b done %b)", cyc, ok, ok2); end
    checks++; if (diff !== 8'd63) begin errors++; $display("FAIL basic_diff got %0d want 63", diff); end
    checks++; if ({borrow_out, ovf} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b want 00", {borrow_out, ovf}); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done got %b want 0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_release got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_idle got %b want 1", in_ready); end
  endtask

  task automatic test_borrow_ovf();
    bit ok, ok2;
    int cyc;
    out_ready = 1'b1;
    accept_op(8'h00, 8'h01, ok);
    wait_done(ok2, cyc);
    checks++; if (!ok || !ok2) begin errors++; $display("FAIL borrow_timeout accept %b done %b", ok, ok2); end
    checks++; if ({diff, borrow_out, ovf} !== {8'hFF, 1'b1, 1'b0}) begin errors++; $display("FAIL borrow_result got %h/%b/%b want ff/1/0", diff, borrow_out, ovf); end
    step();
    accept_op(8'h80, 8'h01, ok);
    wait_done(ok2, cyc);
    checks++; if (!ok || !ok2) begin errors++; $display("FAIL ovf_timeout accept %b done %b", ok, ok2); end
    checks++; if ({diff, borrow_out, ovf} !== {8'h7F, 1'b0, 1'b1}) begin errors++; $display("FAIL ovf_result got %h/%b/%b want 7f/0/1", diff, borrow_out, ovf); end
    step();
  endtask

  task automatic test_backpressure();
    bit ok, bad_run, bad_hold;
    int n;
    out_ready = 1'b0;
    accept_op(8'h55, 8'h0F, ok);
    a = 8'hFF;
    bad_run = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      in_valid = ~in_valid;
      if (in_ready) bad_run = 1'b1;
      step();
      n++;
    end
    checks++; if (!ok || !out_valid) begin errors++; $display("FAIL bp_timeout accept %b valid %b", ok, out_valid); end
    checks++; if (bad_run) begin errors++; $display("FAIL bp_in_ready_run got 1 want 0"); end
    bad_hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      step();
      if (diff !== 8'h46 || out_valid !== 1'b1 || in_ready !== 1'b0) bad_hold = 1'b1;
    end
    checks++; if (bad_hold) begin errors++; $display("FAIL bp_hold diff %h valid %b in_ready %b want 46/1/0", diff, out_valid, in_ready); end
    checks++; if ({diff, borrow_out, ovf} !== {8'h46, 1'b0, 1'b0}) begin errors++; $display("FAIL bp_result got %h/%b/%b want 46/0/0", diff, borrow_out, ovf); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release valid %b in_ready %b want 0/1", out_valid, in_ready); end
    step(); step();
    checks++; if (in_ready !== 1'b1 || diff !== 8'h46) begin errors++; $display("FAIL bp_no_second_op in_ready %b diff %h want 1/46", in_ready, diff); end
  endtask

  task automatic test_reset_midop();
    bit ok, ok2, rose;
    int cyc;
    out_ready = 1'b1;
    accept_op(8'hF0, 8'h0F, ok);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL abort_flags valid %b in_ready %b want 0/0", out_valid, in_ready); end
    checks++; if ({diff, borrow_out, ovf} !== 10'h000) begin errors++; $display("FAIL abort_outputs got %h/%b/%b want 00/0/0", diff, borrow_out, ovf); end
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
    rose = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) rose = 1'b1;
      step();
    end
    checks++; if (rose || !ok) begin errors++; $display("FAIL abort_no_valid rose %b accept %b want 0/1", rose, ok); end
    accept_op(8'h10, 8'h20, ok);
    wait_done(ok2, cyc);
    checks++; if (!ok || !ok2) begin errors++; $display("FAIL abort_new_timeout accept %b done %b", ok, ok2); end
    checks++; if ({diff, borrow_out, ovf} !== {8'hF0, 1'b1, 1'b0}) begin errors++; $display("FAIL abort_new_result got %h/%b/%b want f0/1/0", diff, borrow_out, ovf); end
    step();
  endtask

  task automatic test_exhaustive4();
    bit ok;
    int n, sa, sb, sd;
    logic [3:0] exp_d;
    logic       exp_b, exp_o;
    out_ready4 = 1'b1;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        a4 = 4'(ai);
        b4 = 4'(bi);
        in_valid4 = 1'b1;
        n = 0;
        while (!in_ready4 && n < 20) begin step(); n++; end
        step();
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 20) begin step(); n++; end
        ok = out_valid4;
        exp_d = 4'(ai - bi);
        exp_b = (ai < bi);
        sa = (ai >= 8) ? ai - 16 : ai;
        sb = (bi >= 8) ? bi - 16 : bi;
        sd = sa - sb;
        exp_o = (sd > 7) || (sd < -8);
        checks++; if (!ok) begin errors++; $display("FAIL ex4_timeout a %0d b %0d", ai, bi); end
        checks++; if (diff4 !== exp_d) begin errors++; $display("FAIL ex4_diff a %0d b %0d got %h want %h", ai, bi, diff4, exp_d); end
        checks++; if (borrow_out4 !== exp_b) begin errors++; $display("FAIL ex4_borrow a %0d b %0d got %b want %b", ai, bi, borrow_out4, exp_b); end
        checks++; if (ovf4 !== exp_o) begin errors++; $display("FAIL ex4_ovf a %0d b %0d got %b want %b", ai, bi, ovf4, exp_o); end
      end
    end
    step(); step();
    checks++; if (pulses4 != 256 || accepts4 != 256) begin errors++; $display("FAIL ex4_pulses got %0d results %0d accepts want 256/256", pulses4, accepts4); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_ovf();
    test_backpressure();
    test_reset_midop();
    test_exhaustive4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
